// File: rtl/dram_ctrl_pkg.sv
// Shared types and width helpers for the DRAM controller front end and controller FSM.
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        REFRESH = 2'd2
    } arb_state_t;

    localparam int OFFSET_W = 10;

    // Address-field widths; never narrower than one bit so degenerate sizes still elaborate.
    function automatic int bank_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer: raises pending at each expiry, flags a sticky overrun
// when an expiry arrives while the previous refresh is still outstanding.
module dram_refresh_timer
    import dram_ctrl_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    output logic pending,
    output logic overrun
);

    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

    logic [TW-1:0] count;
    logic          expire;

    assign expire = (count == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count   <= RELOAD;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            count <= expire ? RELOAD : count - 1'b1;
            // A new expiry outranks a same-cycle clear so no refresh is ever lost.
            if (expire)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
            if (expire && pending)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// Round-robin front end for dram_ctrl_fsm: grants one requester per burst, latches its
// address fields, and slots refresh requests in between bursts.
module dram_req_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int NUMBER_OF_BANKS  = 8,
    parameter int NUMBER_OF_ROWS   = 128,
    parameter int NUMBER_OF_COLS   = 8,
    parameter int REFRESH_INTERVAL = 780,
    localparam int BW = bank_width(NUMBER_OF_BANKS),
    localparam int RW = row_width(NUMBER_OF_ROWS),
    localparam int CW = col_width(NUMBER_OF_COLS)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BW-1:0]        req_bank,
    input  logic [NUM_REQ*RW-1:0]        req_row,
    input  logic [NUM_REQ*OFFSET_W-1:0]  req_offset,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         addr_val,
    output logic [BW-1:0]                bank_id,
    output logic [RW-1:0]                row_id,
    output logic [CW-1:0]                col_id,
    output logic [OFFSET_W-1:0]          offset,
    output logic                         refresh_flag,
    input  logic                         access_done,
    input  logic                         refresh_done,
    output logic                         refresh_overrun
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][BW-1:0]       bank_arr;
    logic [NUM_REQ-1:0][RW-1:0]       row_arr;
    logic [NUM_REQ-1:0][OFFSET_W-1:0] off_arr;

    assign bank_arr = req_bank;
    assign row_arr  = req_row;
    assign off_arr  = req_offset;

    arb_state_t state, state_nxt;

    logic [IW-1:0]       ptr, owner, pick, idx;
    logic                pick_vld;
    logic                take, finish, ref_clear, ref_pending;
    logic [10:0]         row_end;
    logic [OFFSET_W-1:0] clamp_off;

    // First requester at or after ptr; scanning downward leaves the nearest hit last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Bursts may not run past the last row; the sum is widened so it cannot wrap.
    always_comb begin
        row_end   = 11'(row_arr[pick]) + 11'(off_arr[pick]);
        clamp_off = off_arr[pick];
        if (row_end > 11'(NUMBER_OF_ROWS - 1))
            clamp_off = OFFSET_W'(NUMBER_OF_ROWS - 1 - int'(row_arr[pick]));
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        finish    = 1'b0;
        ref_clear = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pending) begin
                    state_nxt = REFRESH;
                end else if (pick_vld) begin
                    state_nxt = BURST;
                    take      = 1'b1;
                end
            end
            BURST: begin
                if (access_done) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            REFRESH: begin
                if (refresh_done) begin
                    state_nxt = IDLE;
                    ref_clear = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            gnt          <= '0;
            done         <= '0;
            addr_val     <= 1'b0;
            bank_id      <= '0;
            row_id       <= '0;
            col_id       <= '0;
            offset       <= '0;
            refresh_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            done         <= '0;
            refresh_flag <= (state_nxt == REFRESH);
            if (take) begin
                owner    <= pick;
                gnt      <= NUM_REQ'(1) << pick;
                addr_val <= 1'b1;
                bank_id  <= bank_arr[pick];
                row_id   <= row_arr[pick];
                col_id   <= '0;
                offset   <= clamp_off;
            end
            if (finish) begin
                gnt      <= '0;
                addr_val <= 1'b0;
                done     <= NUM_REQ'(1) << owner;
                ptr      <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clear   (ref_clear),
        .pending (ref_pending),
        .overrun (refresh_overrun)
    );

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Bench for dram_req_arbiter: directed scenarios plus random traffic, compared every cycle
// against a transaction-level reference model of the arbiter and refresh timer.
module tb_dram_req_arbiter;

    localparam int N   = 4;
    localparam int BW  = 3;
    localparam int RW  = 7;
    localparam int CW  = 3;
    localparam int OW  = 10;
    localparam int RI  = 50;
    localparam int ROWS = 128;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [N-1:0]      req;
    logic [N*BW-1:0]   req_bank;
    logic [N*RW-1:0]   req_row;
    logic [N*OW-1:0]   req_offset;
    logic [N-1:0]      gnt, done;
    logic              addr_val, refresh_flag, refresh_overrun;
    logic [BW-1:0]     bank_id;
    logic [RW-1:0]     row_id;
    logic [CW-1:0]     col_id;
    logic [OW-1:0]     offset;
    logic              access_done, refresh_done;

    dram_req_arbiter #(
        .NUM_REQ(N), .NUMBER_OF_BANKS(8), .NUMBER_OF_ROWS(ROWS),
        .NUMBER_OF_COLS(8), .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .req_bank(req_bank), .req_row(req_row),
        .req_offset(req_offset), .gnt(gnt), .done(done), .addr_val(addr_val),
        .bank_id(bank_id), .row_id(row_id), .col_id(col_id), .offset(offset),
        .refresh_flag(refresh_flag), .access_done(access_done),
        .refresh_done(refresh_done), .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 serving a burst, 2 refreshing.
    int           t, m_mode, m_owner, m_ptr;
    bit           m_pending, m_overrun, m_flag, m_addr;
    logic [N-1:0] m_gnt, m_done;
    logic [BW-1:0] m_bank;
    logic [RW-1:0] m_row;
    logic [CW-1:0] m_col;
    logic [OW-1:0] m_off;

    // Controller / requester emulation knobs.
    int acc_cnt, acc_lat, ref_cnt, ref_lat;
    bit rnd;

    task automatic model_reset();
        t = 0; m_mode = 0; m_owner = 0; m_ptr = 0;
        m_pending = 0; m_overrun = 0; m_flag = 0; m_addr = 0;
        m_gnt = '0; m_done = '0; m_bank = '0; m_row = '0; m_col = '0; m_off = '0;
        acc_cnt = 0; ref_cnt = 0;
    endtask

    // The timer expires on every edge whose index is RI-1 modulo RI after reset release.
    task automatic model_edge();
        bit expire, clr, found;
        int row, off;
        expire = (t % RI) == RI - 1;
        clr    = 0;
        found  = 0;
        m_done = '0;
        case (m_mode)
            0: begin
                if (m_pending) begin
                    m_mode = 2;
                    m_flag = 1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr + k) % N;
                        if (!found && req[i]) begin
                            found = 1;
                            m_owner = i;
                        end
                    end
                    if (found) begin
                        m_mode = 1;
                        m_addr = 1;
                        m_gnt  = '0;
                        m_gnt[m_owner] = 1'b1;
                        m_bank = req_bank[m_owner*BW +: BW];
                        m_row  = req_row[m_owner*RW +: RW];
                        m_col  = '0;
                        row = int'(req_row[m_owner*RW +: RW]);
                        off = int'(req_offset[m_owner*OW +: OW]);
                        m_off = (row + off > ROWS - 1) ? OW'(ROWS - 1 - row) : OW'(off);
                    end
                end
            end
            1: begin
                if (access_done) begin
                    m_done[m_owner] = 1'b1;
                    m_gnt  = '0;
                    m_addr = 0;
                    m_ptr  = (m_owner + 1) % N;
                    m_mode = 0;
                end
            end
            default: begin
                if (refresh_done) begin
                    m_flag = 0;
                    clr    = 1;
                    m_mode = 0;
                end
            end
        endcase
        if (expire) begin
            if (m_pending) m_overrun = 1;
            m_pending = 1;
        end else if (clr) begin
            m_pending = 0;
        end
        t++;
    endtask

    task automatic check();
        total++;
        assert (gnt === m_gnt) else begin
            bad++; $error("FAIL gnt t=%0d got=%b want=%b", t, gnt, m_gnt);
        end
        total++;
        assert (done === m_done) else begin
            bad++; $error("FAIL done t=%0d got=%b want=%b", t, done, m_done);
        end
        total++;
        assert (addr_val === m_addr) else begin
            bad++; $error("FAIL addr_val t=%0d got=%b want=%b", t, addr_val, m_addr);
        end
        total++;
        assert ({bank_id, row_id, col_id, offset} === {m_bank, m_row, m_col, m_off}) else begin
            bad++; $error("FAIL fields t=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", t,
                          bank_id, row_id, col_id, offset, m_bank, m_row, m_col, m_off);
        end
        total++;
        assert ({refresh_flag, refresh_overrun} === {m_flag, m_overrun}) else begin
            bad++; $error("FAIL refresh t=%0d got=%b%b want=%b%b", t,
                          refresh_flag, refresh_overrun, m_flag, m_overrun);
        end
    endtask

    task automatic set_req(input int i, input int bank, input int row, input int off);
        req[i] = 1'b1;
        req_bank[i*BW +: BW]   = BW'(bank);
        req_row[i*RW +: RW]    = RW'(row);
        req_offset[i*OW +: OW] = OW'(off);
    endtask

    // Behaves as the requesters and the controller for the next cycle.
    task automatic drive();
        access_done  = 1'b0;
        refresh_done = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_done[i]) req[i] = 1'b0;
        if (m_addr) begin
            acc_cnt++;
            if (acc_cnt >= acc_lat) access_done = 1'b1;
        end else begin
            acc_cnt = 0;
            if (rnd) acc_lat = $urandom_range(1, 6);
        end
        if (m_flag) begin
            ref_cnt++;
            if (ref_cnt >= ref_lat) refresh_done = 1'b1;
        end else begin
            ref_cnt = 0;
            if (rnd) ref_lat = $urandom_range(1, 5);
        end
        if (rnd) begin
            if (!m_addr && $urandom_range(0, 3) == 0) access_done = 1'b1;
            if (!m_flag && $urandom_range(0, 3) == 0) refresh_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 5) == 0)
                    set_req(i, $urandom_range(0, 7), $urandom_range(0, ROWS - 1),
                            $urandom_range(0, 1) ? $urandom_range(0, 30) : $urandom_range(0, 1023));
                else if (m_gnt[i] && $urandom_range(0, 15) == 0)
                    req[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            check();
            drive();
        end
    endtask

    task automatic wait_done(input int i, input string tag);
        for (int b = 0; b < 300 && !m_done[i]; b++) run(1);
        total++;
        assert (m_done[i]) else begin
            bad++; $error("FAIL %s timeout got=%b want=done[%0d]", tag, done, i);
        end
    endtask

    initial begin
        rst_b = 1'b0; req = '0; req_bank = '0; req_row = '0; req_offset = '0;
        access_done = 1'b0; refresh_done = 1'b0;
        rnd = 0; acc_lat = 3; ref_lat = 3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check();
        rst_b = 1'b1;

        // Quiet after reset: nothing moves for 20 cycles.
        run(20);

        // Round robin from ptr 0 over requesters 1 and 3.
        set_req(1, 2, 10, 5);
        set_req(3, 6, 40, 3);
        run(1);
        total++;
        assert (gnt === 4'b0010) else begin
            bad++; $error("FAIL first_grant got=%b want=%b", gnt, 4'b0010);
        end
        wait_done(1, "burst1");
        run(1);
        total++;
        assert (gnt === 4'b1000) else begin
            bad++; $error("FAIL k_plus_2_grant got=%b want=%b", gnt, 4'b1000);
        end
        wait_done(3, "burst3");
        set_req(0, 1, 0, 0);
        set_req(1, 1, 0, 0);
        run(2);
        total++;
        assert (gnt === 4'b0001) else begin
            bad++; $error("FAIL ptr_wrap got=%b want=%b", gnt, 4'b0001);
        end
        wait_done(0, "burst0");
        wait_done(1, "burst1b");

        // Offset clamp at the top of the row space.
        set_req(2, 5, 120, 20);
        for (int b = 0; b < 100 && m_gnt == '0; b++) run(1);
        total++;
        assert ({bank_id, row_id, col_id, offset} === {3'd5, 7'd120, 3'd0, 10'd7}) else begin
            bad++; $error("FAIL clamp got=%0d/%0d/%0d/%0d want=5/120/0/7",
                          bank_id, row_id, col_id, offset);
        end
        wait_done(2, "clamp_burst");

        // Long burst straddles two expiries; refresh must precede the waiting requester.
        acc_lat = 100;
        set_req(0, 3, 7, 9);
        run(5);
        set_req(3, 4, 50, 10);
        wait_done(0, "long_burst");
        acc_lat = 3;
        for (int b = 0; b < 20 && !m_flag; b++) run(1);
        total++;
        assert ({refresh_flag, gnt, refresh_overrun} === {1'b1, 4'b0000, 1'b1}) else begin
            bad++; $error("FAIL refresh_first got=%b/%b/%b want=1/0000/1",
                          refresh_flag, gnt, refresh_overrun);
        end
        wait_done(3, "after_refresh");

        // Request arriving with a fresh expiry in IDLE: refresh goes first.
        for (int b = 0; b < 300 && !(m_mode == 0 && m_pending && (t % RI) == 0); b++) run(1);
        total++;
        assert (m_mode == 0 && m_pending) else begin
            bad++; $error("FAIL expiry_align timeout got=mode%0d want=idle_pending", m_mode);
        end
        set_req(2, 1, 1, 1);
        run(1);
        total++;
        assert ({refresh_flag, gnt} === {1'b1, 4'b0000}) else begin
            bad++; $error("FAIL same_cycle got=%b/%b want=1/0000", refresh_flag, gnt);
        end
        wait_done(2, "post_refresh_grant");

        // Random traffic with stray handshakes and mid-burst request drops.
        rnd = 1;
        run(1500);
        rnd = 0;
        req = '0;
        acc_lat = 3; ref_lat = 3;
        run(20);

        // Reset in the middle of a burst.
        acc_lat = 50;
        set_req(2, 7, 3, 4);
        for (int b = 0; b < 100 && !m_addr; b++) run(1);
        run(3);
        rst_b = 1'b0;
        #1;
        total++;
        assert ({addr_val, gnt, done, refresh_flag} === 10'b0) else begin
            bad++; $error("FAIL async_reset got=%b/%b/%b/%b want=0", addr_val, gnt, done, refresh_flag);
        end
        model_reset();
        req = '0; access_done = 1'b0; refresh_done = 1'b0; acc_lat = 3;
        check();
        @(posedge clk);
        #1;
        check();
        rst_b = 1'b1;
        run(2);
        req = '1;
        run(1);
        total++;
        assert (gnt === 4'b0001) else begin
            bad++; $error("FAIL ptr_after_reset got=%b want=%b", gnt, 4'b0001);
        end
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_req_arbiter.md
# dram_req_arbiter

Front-end scheduler for `dram_ctrl_fsm`. It shares the single controller between `NUM_REQ` requesters using round-robin arbitration and presents the winning request as one `addr_val` burst. It also owns the periodic refresh timer and drives `refresh_flag` only between bursts. It sits between the requester ports and the controller's address, `addr_val` and `refresh_flag` inputs.

## Interface
- `NUM_REQ`, 4, number of requesters
- `NUMBER_OF_BANKS`, 8, banks; `BW = $clog2(NUMBER_OF_BANKS)`
- `NUMBER_OF_ROWS`, 128, rows; `RW = $clog2(NUMBER_OF_ROWS)`
- `NUMBER_OF_COLS`, 8, columns; `CW = $clog2(NUMBER_OF_COLS)`
- `REFRESH_INTERVAL`, 780, clock cycles between refresh requests (≥ 2)

Ports (clock and reset first):
- `clk` in 1: single clock, all logic on the rising edge
- `rst_b` in 1: asynchronous, active-low reset
- `req` in NUM_REQ: level request per requester, held until its `done` pulse
- `req_bank` in NUM_REQ*BW: packed bank per requester (requester i at `[i*BW +: BW]`)
- `req_row` in NUM_REQ*RW: packed start row
- `req_offset` in NUM_REQ*10: packed row count
- `gnt` out NUM_REQ: one-hot, high for the whole burst
- `done` out NUM_REQ: one-cycle pulse to the served requester
- `addr_val` out 1: burst valid to controller
- `bank_id` out BW, `row_id` out RW, `col_id` out CW, `offset` out 10: latched burst fields
- `refresh_flag` out 1: refresh request to controller
- `access_done` in 1: controller pulse, last access of the burst complete
- `refresh_done` in 1: controller pulse, refresh complete
- `refresh_overrun` out 1: sticky; a refresh interval expired while the previous refresh was still pending

## Operation
- States: IDLE, BURST, REFRESH.
- **IDLE**
  - If `refresh_pending` is set, go to REFRESH. Refresh beats requests on a simultaneous event.
  - Otherwise, if any `req` is high, pick the first high `req` searching from `ptr` upward with wrap. Latch that requester's fields into `bank_id`/`row_id`/`offset`, set `col_id = 0`, set `gnt[i]`, and go to BURST.
- **BURST**
  - `addr_val = 1`.
  - On `access_done`: clear `addr_val` and `gnt`, pulse `done[i]`, set `ptr = (i+1) mod NUM_REQ`, and return to IDLE.
  - Dropping `req[i]` mid-burst is ignored; the burst completes.
- **REFRESH**
  - `refresh_flag = 1`.
  - On `refresh_done`: clear `refresh_flag` and `refresh_pending`, and return to IDLE.
- Stray handshake pulses are ignored: `access_done` outside BURST and `refresh_done` outside REFRESH.
- Refresh timer
  - Down-counter, reloads `REFRESH_INTERVAL-1` at 0, and runs in every state.
  - At 0 it sets `refresh_pending`.
  - If `refresh_pending` is already set at that moment, it sets `refresh_overrun`.
  - If expiry and the `refresh_done` clear land in the same cycle, the set wins.
- Offset clamp: if `req_row + req_offset > NUMBER_OF_ROWS-1`, latch `offset = NUMBER_OF_ROWS-1-req_row`. Compute the sum in 11 bits.
- Reset values: all outputs 0, `ptr = 0`, timer = `REFRESH_INTERVAL-1`, state IDLE, `refresh_pending = 0`.
- Reset mid-burst or mid-refresh aborts immediately. No `done` pulse is produced.

## Timing
- All outputs are registered.
- `req` sampled high in IDLE at edge N → `gnt`, `addr_val` and fields valid from edge N+1.
- `access_done` sampled at edge K → `addr_val`/`gnt` low and `done` high from K+1; `done` low at K+2.
- Earliest next grant: edge K+2, so there is exactly one IDLE cycle between bursts.
- Refresh pending in IDLE at edge N → `refresh_flag` from N+1; it falls one cycle after `refresh_done` is sampled.
- Expiry during BURST holds `refresh_pending`; `refresh_flag` rises at K+2, ahead of any waiting requester.
- Fields are stable for the entire burst.

## Structure
- Package `dram_ctrl_pkg`:
  - state enum `arb_state_t` (IDLE/BURST/REFRESH)
  - `OFFSET_W = 10`
  - the bank/row/col width functions shared with `dram_ctrl_fsm`
- Sub-module `dram_refresh_timer`:
  - inputs: `clk`, `rst_b`, `clear`
  - outputs: `pending`, `overrun`
  - parameter: `REFRESH_INTERVAL`
- The arbiter, latch and FSM stay in the top module.

## Test plan
- Reset, no requests for 20 cycles → all outputs 0; state stays IDLE.
- `req = 4'b1010`, `ptr = 0`: grant 1, `access_done`, `done[1]` pulse; next grant 3 at exactly K+2; then `ptr = 0`.
- Requester 2: row 120, offset 20 → latched `offset = 7`, `col_id = 0`, `bank_id` matches.
- `REFRESH_INTERVAL = 50`, expiry during a 100-cycle burst → `refresh_flag` only after the burst, before a pending `req`; a second expiry before `refresh_done` sets `refresh_overrun`.
- Same-cycle `req` and refresh expiry in IDLE → REFRESH first; grant follows 2 cycles after `refresh_done`.
- `rst_b` low mid-burst → `addr_val`/`gnt` clear immediately, no `done` pulse, `ptr = 0` after release.
